uart_frame_parser: RTL



---
 rtl/uart_frame_parser.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Byte-level frame delineator behind the UART receiver: SYNC, LEN, payload, CHK.
// Streams payload bytes as they arrive and flags each frame as ok or failed.
module uart_frame_parser #(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 105600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_d,
  input  logic [7:0] rx_rec,
  output logic       pl_valid,
  output logic [7:0] pl_data,
  output logic       pl_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_len
);

  localparam int         TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  // Timeout fires on the idle edge that would carry the counter to TIMEOUT_CLKS-1
  localparam logic [TW-1:0] TC_PRE = TW'(TIMEOUT_CLKS - 2);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pl_valid_d, pl_last_d, frame_ok_d, frame_err_d;
  logic [7:0]    pl_data_d, frame_len_d;
  logic [1:0]    err_code_d;
  logic          timeout;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tcnt_d      = '0;
    pl_valid_d  = 1'b0;
    pl_data_d   = pl_data;
    pl_last_d   = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code;
    frame_len_d = frame_len;
    timeout     = (state_q != IDLE) && !rx_d && (tcnt_q == TC_PRE);

    if (state_q != IDLE && !rx_d)
      tcnt_d = tcnt_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (rx_d && rx_rec == SYNC_BYTE)
          state_d = LEN;
      end
      LEN: begin
        if (rx_d) begin
          if (rx_rec == 8'd0 || rx_rec > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
            frame_len_d = rx_rec;
            state_d     = IDLE;
          end else begin
            len_d   = rx_rec;
            acc_d   = rx_rec;
            cnt_d   = 8'd0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // A SYNC value here is ordinary data; only the length ends the payload
        if (rx_d) begin
          pl_valid_d = 1'b1;
          pl_data_d  = rx_rec;
          acc_d      = acc_q ^ rx_rec;
          cnt_d      = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) begin
            pl_last_d = 1'b1;
            state_d   = CHK;
          end
        end
      end
      CHK: begin
        if (rx_d) begin
          if (rx_rec == acc_q) begin
            frame_ok_d  = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
          end
          frame_len_d = len_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'b11;
      frame_len_d = (state_q == LEN) ? 8'd0 : len_q;
      tcnt_d      = '0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      pl_valid  <= 1'b0;
      pl_data   <= '0;
      pl_last   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      frame_len <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      pl_valid  <= pl_valid_d;
      pl_data   <= pl_data_d;
      pl_last   <= pl_last_d;
      frame_ok  <= frame_ok_d;
      frame_err <= frame_err_d;
      err_code  <= err_code_d;
      frame_len <= frame_len_d;
    end
  end

endmodule
